// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive/transmit pair: the receiver state
//   encoding, the serial line levels, and the default frame geometry. The
//   frame geometry defaults are also used by uart_tx, so both ends agree on
//   the frame format.
package uart_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    // Serial line levels: the line idles high, and a start bit is a low level.
    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    // Default frame geometry.
    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// uart_sync
//   Two-flop synchroniser for a single asynchronous input. The reset value is
//   a parameter, so an idle-high serial line can leave reset already reading
//   idle. This avoids a false edge when reset is released.
//   Ports:
//     clk     - destination clock
//     rst     - asynchronous, active-high reset (both flops load RST_VAL)
//     async_i - asynchronous input
//     sync_o  - synchronised copy of async_i, two clk edges late
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule : uart_sync

// File: rtl/uart_rx.sv
// uart_rx
//   Receiver for 8N1-style serial frames. The line idles high and data is sent
//   LSB first, with one start bit and one stop bit. The raw line is first
//   synchronised. A start bit is then confirmed at its half-bit point, and
//   every later bit is sampled one full bit period after the previous sample,
//   which places each sample at the bit centre.
//   Ports:
//     clk              - system clock
//     rst              - asynchronous, active-high reset
//     rx_data_in       - raw serial line (asynchronous, idle high)
//     rx_data_out      - last correctly framed word; bit 0 is the first bit received
//     rx_valid_out     - one-cycle pulse when rx_data_out has just been updated
//     rx_frame_err_out - one-cycle pulse when a stop bit was sampled low
//     rx_busy_out      - high while a frame is in progress, or while waiting
//                        for the line to return high after a framing error
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_data_in,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid_out,
    output logic                 rx_frame_err_out,
    output logic                 rx_busy_out
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] HALF_M1   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

    logic rx_sync;

    uart_sync #(
        .RST_VAL (UART_IDLE_LVL)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (rx_data_in),
        .sync_o  (rx_sync)
    );

    uart_rx_state_t       state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        index_q, index_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            index_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            index_q <= index_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        index_d = index_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                index_d = '0;
                if (rx_sync == UART_START_LVL) begin
                    state_d = START;
                end
            end

            START: begin
                // At the half-bit point, re-check the line. A pulse shorter
                // than half a bit is treated as noise and the frame is dropped.
                if (timer_q == HALF_M1) begin
                    timer_d = '0;
                    index_d = '0;
                    if (rx_sync == UART_START_LVL) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (timer_q == LAST_TICK) begin
                    timer_d = '0;
                    // LSB first: each new bit enters at the top, so after
                    // DATA_BITS shifts the first bit received sits in bit 0.
                    shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        state_d = STOP;
                    end else begin
                        index_d = index_q + IW'(1);
                    end
                end
            end

            STOP: begin
                if (timer_q == LAST_TICK) begin
                    timer_d = '0;
                    index_d = '0;
                    if (rx_sync == UART_IDLE_LVL) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Keep the last good word. Wait for the line to return
                        // high, so a held-low line reports only one error.
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                timer_d = '0;
                index_d = '0;
                if (rx_sync == UART_IDLE_LVL) begin
                    state_d = IDLE;
                end
            end

            default: begin
                timer_d = '0;
                index_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data_out      = data_q;
    assign rx_valid_out     = valid_q;
    assign rx_frame_err_out = err_q;
    // Derived from the state register: busy drops in the same cycle as the
    // valid pulse, because the FSM returns to IDLE on the stop-sample edge.
    assign rx_busy_out      = (state_q != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Directed bench for uart_rx at CLKS_PER_BIT = 16 and DATA_BITS = 8.
//   The line is driven on falling edges, and P is the rising-edge count at
//   the moment the start bit is driven. T0 = P + 3: the line is seen at P+1,
//   then by the second flop at P+2, and the FSM enters START at P+3. The stop
//   bit is sampled on edge T0 + 152. The resulting valid pulse is therefore
//   seen at edge T0 + 153 = P + 156.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_line = 1'b1;
    logic [DB-1:0] rx_data_out;
    logic          rx_valid_out;
    logic          rx_frame_err_out;
    logic          rx_busy_out;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_data_in       (rx_line),
        .rx_data_out      (rx_data_out),
        .rx_valid_out     (rx_valid_out),
        .rx_frame_err_out (rx_frame_err_out),
        .rx_busy_out      (rx_busy_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records each valid pulse as data plus the edge number on which
    // it is seen high, and counts error pulses.
    logic [7:0] vq[$];
    int         vt[$];
    int         ecnt = 0;
    int         et   = -1;
    int         both = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid_out && rx_frame_err_out) both++;
            if (rx_valid_out) begin
                vq.push_back(rx_data_out);
                vt.push_back(cyc + 1);
            end
            if (rx_frame_err_out) begin
                ecnt++;
                et = cyc + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
        $display("check %-20s observed %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic logic [31:0] getv(input int i);
        if (i < vq.size()) return {24'h0, vq[i]};
        return 'x;
    endfunction

    function automatic logic [31:0] gett(input int i);
        if (i < vt.size()) return vt[i];
        return 'x;
    endfunction

    task automatic drive_bit(input logic v, input int n);
        rx_line = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < DB; i++) drive_bit(b[i], CPB);
        drive_bit(stop_bit, CPB);
    endtask

    task automatic clear_log();
        vq.delete();
        vt.delete();
    endtask

    int            p;
    int            e0;
    logic [7:0]    b;
    logic [7:0]    exp_q[$];
    logic [7:0]    f3;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data",  {24'h0, rx_data_out}, 32'h0);
        check("rst_valid", {31'h0, rx_valid_out}, 32'h0);
        check("rst_err",   {31'h0, rx_frame_err_out}, 32'h0);
        check("rst_busy",  {31'h0, rx_busy_out}, 32'h0);
        rst = 1'b0;
        drive_bit(1'b1, 20);
        check("idle_busy", {31'h0, rx_busy_out}, 32'h0);

        // Single frame 0xA5
        clear_log();
        e0 = ecnt;
        p  = cyc;
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, 20);
        check("a5_count", vq.size(), 32'd1);
        check("a5_data",  getv(0), 32'hA5);
        check("a5_time",  gett(0), p + 156);
        check("a5_err",   ecnt, e0);
        check("a5_hold",  {24'h0, rx_data_out}, 32'hA5);

        // Three back-to-back frames with no gap
        clear_log();
        p = cyc;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        drive_bit(1'b1, 20);
        check("b2b_count", vq.size(), 32'd3);
        check("b2b_d0", getv(0), 32'h00);
        check("b2b_d1", getv(1), 32'hFF);
        check("b2b_d2", getv(2), 32'h3C);
        check("b2b_t0", gett(0), p + 156);
        check("b2b_t1", gett(1), p + 316);
        check("b2b_t2", gett(2), p + 476);

        // Short low glitch, then a real frame 0x5A
        clear_log();
        e0 = ecnt;
        p  = cyc;
        drive_bit(1'b0, 4);
        rx_line = 1'b1;
        repeat (6) @(negedge clk);
        check("glitch_busy_t0p7", {31'h0, rx_busy_out}, 32'h1);
        @(negedge clk);
        check("glitch_busy_t0p8", {31'h0, rx_busy_out}, 32'h0);
        drive_bit(1'b1, 30);
        check("glitch_novalid", vq.size(), 32'd0);
        check("glitch_noerr",   ecnt, e0);
        p = cyc;
        send_frame(8'h5A, 1'b1);
        drive_bit(1'b1, 20);
        check("5a_count", vq.size(), 32'd1);
        check("5a_data",  getv(0), 32'h5A);
        check("5a_time",  gett(0), p + 156);

        // Framing error: 0x81 with a low stop bit, then the line held low
        clear_log();
        e0 = ecnt;
        p  = cyc;
        send_frame(8'h81, 1'b0);
        drive_bit(1'b0, 50);
        check("ferr_count", ecnt, e0 + 1);
        check("ferr_time",  et, p + 156);
        check("ferr_novalid", vq.size(), 32'd0);
        check("ferr_hold",  {24'h0, rx_data_out}, 32'h5A);
        check("ferr_busy_low", {31'h0, rx_busy_out}, 32'h1);
        rx_line = 1'b1;
        repeat (2) @(negedge clk);
        check("ferr_busy_hi2", {31'h0, rx_busy_out}, 32'h1);
        @(negedge clk);
        check("ferr_busy_hi3", {31'h0, rx_busy_out}, 32'h0);
        drive_bit(1'b1, 40);
        check("ferr_single", ecnt, e0 + 1);

        // Reset during data bit 4 of frame 0xF3
        clear_log();
        e0 = ecnt;
        f3 = 8'hF3;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(f3[i], CPB);
        rx_line = f3[4];
        repeat (8) @(negedge clk);
        check("prerst_busy", {31'h0, rx_busy_out}, 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_data",  {24'h0, rx_data_out}, 32'h0);
        check("midrst_valid", {31'h0, rx_valid_out}, 32'h0);
        check("midrst_err",   {31'h0, rx_frame_err_out}, 32'h0);
        check("midrst_busy",  {31'h0, rx_busy_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        for (int i = 5; i < DB; i++) drive_bit(f3[i], CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b1, CPB);
        check("postrst_novalid", vq.size(), 32'd0);
        check("postrst_noerr",   ecnt, e0);
        check("postrst_data",    {24'h0, rx_data_out}, 32'h0);
        p = cyc;
        send_frame(8'h69, 1'b1);
        drive_bit(1'b1, 20);
        check("69_count", vq.size(), 32'd1);
        check("69_data",  getv(0), 32'h69);
        check("69_time",  gett(0), p + 156);

        // 256 random bytes sent back-to-back, acting as a transmitter
        clear_log();
        e0 = ecnt;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
        end
        drive_bit(1'b1, 20);
        check("loop_count", vq.size(), 32'd256);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("loop_%0d", i), getv(i), {24'h0, exp_q[i]});
        end
        check("loop_noerr", ecnt, e0);
        check("never_both", both, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule : tb_uart_rx
